// File: rtl/regfile_wb_arbiter.sv
// Collects functional-unit results into per-source FIFOs and drains them round-robin
// onto registered regfile write ports, exporting a pending-write mask for hazard checks.
module regfile_wb_arbiter #(
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter bit          ZERO_REG_ZERO   = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    output logic [NR_WB_PORTS-1:0]                 wb_ready_o,
    input  logic [NR_WB_PORTS*5-1:0]               wb_addr_i,
    input  logic [NR_WB_PORTS*DATA_WIDTH-1:0]      wb_data_i,
    output logic [NR_COMMIT_PORTS*5-1:0]           waddr_o,
    output logic [NR_COMMIT_PORTS*DATA_WIDTH-1:0]  wdata_o,
    output logic [NR_COMMIT_PORTS-1:0]             we_o,
    output logic [31:0]                            pending_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RR_W  = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

    // FIFO storage and bookkeeping
    logic [4:0]            addr_q   [NR_WB_PORTS][FIFO_DEPTH];
    logic [4:0]            addr_d   [NR_WB_PORTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [NR_WB_PORTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [NR_WB_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q [NR_WB_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [NR_WB_PORTS];
    logic [PTR_W-1:0]      wr_ptr_q [NR_WB_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [NR_WB_PORTS];
    logic [CNT_W-1:0]      cnt_q    [NR_WB_PORTS];
    logic [CNT_W-1:0]      cnt_d    [NR_WB_PORTS];

    // Arbiter and output registers
    logic [RR_W-1:0]            rr_q, rr_d;
    logic [NR_COMMIT_PORTS-1:0] we_q, we_d;
    logic [4:0]                 waddr_q [NR_COMMIT_PORTS];
    logic [4:0]                 waddr_d [NR_COMMIT_PORTS];
    logic [DATA_WIDTH-1:0]      wdata_q [NR_COMMIT_PORTS];
    logic [DATA_WIDTH-1:0]      wdata_d [NR_COMMIT_PORTS];
    logic [31:0]                pending_q, pending_d;

    // Combinational arbitration results
    logic [4:0]                 head_addr [NR_WB_PORTS];
    logic [DATA_WIDTH-1:0]      head_data [NR_WB_PORTS];
    logic [NR_WB_PORTS-1:0]     pop;
    logic [NR_COMMIT_PORTS-1:0] gnt_vld;
    logic [4:0]                 gnt_addr [NR_COMMIT_PORTS];
    logic [DATA_WIDTH-1:0]      gnt_data [NR_COMMIT_PORTS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return PTR_W'((int'(p) + 1) % int'(FIFO_DEPTH));
    endfunction

    always_comb begin : ready_gen
        wb_ready_o = '0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            wb_ready_o[k] = (cnt_q[k] != CNT_W'(FIFO_DEPTH)) & ~flush_i;
        end
    end

    always_comb begin : head_sel
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            head_addr[k] = addr_q[k][rd_ptr_q[k]];
            head_data[k] = data_q[k][rd_ptr_q[k]];
        end
    end

    // Round-robin scan from rr; a head whose address is already granted this cycle waits.
    always_comb begin : arb
        logic [RR_W-1:0] src;
        logic            conflict;
        logic            placed;
        pop      = '0;
        gnt_vld  = '0;
        rr_d     = rr_q;
        src      = '0;
        conflict = 1'b0;
        placed   = 1'b0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            gnt_addr[p] = '0;
            gnt_data[p] = '0;
        end
        for (int i = 0; i < NR_WB_PORTS; i++) begin
            src      = RR_W'((int'(rr_q) + i) % int'(NR_WB_PORTS));
            conflict = 1'b0;
            placed   = 1'b0;
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (gnt_vld[p] && (gnt_addr[p] == head_addr[src])) begin
                    conflict = 1'b1;
                end
            end
            if ((cnt_q[src] != '0) && !conflict) begin
                for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                    if (!placed && !gnt_vld[p]) begin
                        gnt_vld[p]  = 1'b1;
                        gnt_addr[p] = head_addr[src];
                        gnt_data[p] = head_data[src];
                        placed      = 1'b1;
                    end
                end
                if (placed) begin
                    pop[src] = 1'b1;
                    rr_d     = RR_W'((int'(src) + 1) % int'(NR_WB_PORTS));
                end
            end
        end
        if (flush_i) begin
            rr_d = '0;
        end
    end

    // FIFO next state; x0 results complete the handshake but are never stored.
    always_comb begin : fifo_next
        logic push;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            push = wb_valid_i[k] & wb_ready_o[k]
                 & ~(ZERO_REG_ZERO && (wb_addr_i[k*5 +: 5] == 5'd0));
            if (push) begin
                addr_d[k][wr_ptr_q[k]] = wb_addr_i[k*5 +: 5];
                data_d[k][wr_ptr_q[k]] = wb_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                wr_ptr_d[k]            = ptr_inc(wr_ptr_q[k]);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
            end
            if (push && !pop[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (!push && pop[k]) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
            if (flush_i) begin
                cnt_d[k]    = '0;
                rd_ptr_d[k] = '0;
                wr_ptr_d[k] = '0;
            end
        end
    end

    always_comb begin : wb_next
        we_d = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            we_d[p]    = gnt_vld[p] & ~flush_i;
            waddr_d[p] = we_d[p] ? gnt_addr[p] : waddr_q[p];
            wdata_d[p] = we_d[p] ? gnt_data[p] : wdata_q[p];
        end
    end

    // Pending mask is built from next state so it lines up with the registers it describes.
    always_comb begin : pending_next
        logic [PTR_W-1:0] off;
        pending_d = '0;
        off       = '0;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                off = PTR_W'(i) - rd_ptr_d[k];
                if (CNT_W'(off) < cnt_d[k]) begin
                    pending_d[addr_d[k][i]] = 1'b1;
                end
            end
        end
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (we_d[p]) begin
                pending_d[waddr_d[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NR_WB_PORTS; k++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    addr_q[k][i] <= '0;
                    data_q[k][i] <= '0;
                end
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                waddr_q[p] <= '0;
                wdata_q[p] <= '0;
            end
            rr_q      <= '0;
            we_q      <= '0;
            pending_q <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rr_q      <= rr_d;
            we_q      <= we_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin : out_pack
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            waddr_o[p*5 +: 5]                   = waddr_q[p];
            wdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_q[p];
        end
        we_o      = we_q;
        pending_o = pending_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter, checked against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int NW = 4;
    localparam int NC = 2;
    localparam int DW = 32;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [NW-1:0]  valid;
    logic [NW-1:0]  wb_ready_o;
    logic [NW*5-1:0]  addr;
    logic [NW*DW-1:0] data;
    logic [NC*5-1:0]  waddr_o;
    logic [NC*DW-1:0] wdata_o;
    logic [NC-1:0]    we_o;
    logic [31:0]      pending_o;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NR_WB_PORTS(NW), .NR_COMMIT_PORTS(NC), .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH), .ZERO_REG_ZERO(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .wb_valid_i(valid), .wb_ready_o(wb_ready_o),
        .wb_addr_i(addr), .wb_data_i(data),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .pending_o(pending_o)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int checks = 0;
    int errors = 0;

    ent_t        mq [NW][$];
    int          m_rr;
    logic [NC-1:0] m_we;
    logic [4:0]  m_waddr [NC];
    logic [31:0] m_wdata [NC];
    logic [31:0] rf_dut [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NW; k++) mq[k].delete();
        m_rr = 0;
        m_we = '0;
        for (int p = 0; p < NC; p++) begin
            m_waddr[p] = '0;
            m_wdata[p] = '0;
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] r = '0;
        for (int k = 0; k < NW; k++)
            foreach (mq[k][i]) r[mq[k][i].a] = 1'b1;
        for (int p = 0; p < NC; p++)
            if (m_we[p]) r[m_waddr[p]] = 1'b1;
        return r;
    endfunction

    function automatic logic [NW-1:0] exp_ready();
        logic [NW-1:0] r = '0;
        for (int k = 0; k < NW; k++) r[k] = (mq[k].size() < DEPTH) && !flush;
        return r;
    endfunction

    // Model of one rising edge: accept, arbitrate heads round-robin, pop, push.
    task automatic model_edge();
        bit          acc [NW];
        logic [4:0]  ga [NC];
        int          ng, last, s;
        bit          conf;
        for (int k = 0; k < NW; k++) acc[k] = valid[k] && (mq[k].size() < DEPTH) && !flush;
        if (flush) begin
            for (int k = 0; k < NW; k++) mq[k].delete();
            m_we = '0;
            m_rr = 0;
            return;
        end
        ng = 0;
        last = -1;
        m_we = '0;
        for (int i = 0; i < NW; i++) begin
            s = (m_rr + i) % NW;
            if (mq[s].size() > 0 && ng < NC) begin
                conf = 0;
                for (int j = 0; j < ng; j++) if (ga[j] == mq[s][0].a) conf = 1;
                if (!conf) begin
                    ga[ng] = mq[s][0].a;
                    m_waddr[ng] = mq[s][0].a;
                    m_wdata[ng] = mq[s][0].d;
                    m_we[ng] = 1'b1;
                    void'(mq[s].pop_front());
                    ng++;
                    last = s;
                end
            end
        end
        if (last >= 0) m_rr = (last + 1) % NW;
        for (int k = 0; k < NW; k++)
            if (acc[k] && addr[k*5 +: 5] != 5'd0)
                mq[k].push_back({addr[k*5 +: 5], data[k*DW +: DW]});
    endtask

    task automatic check_outs();
        chk("we_o", 32'(we_o), 32'(m_we));
        for (int p = 0; p < NC; p++) begin
            chk($sformatf("waddr_o[%0d]", p), 32'(waddr_o[p*5 +: 5]), 32'(m_waddr[p]));
            chk($sformatf("wdata_o[%0d]", p), wdata_o[p*DW +: DW], m_wdata[p]);
            if (we_o[p]) rf_dut[waddr_o[p*5 +: 5]] = wdata_o[p*DW +: DW];
        end
        chk("pending_o", pending_o, exp_pending());
    endtask

    // One clock: check ready with current inputs, take the edge, check registered outputs.
    task automatic cyc();
        #1;
        chk("wb_ready_o", 32'(wb_ready_o), 32'(exp_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic drv(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
        valid[k] = v;
        addr[k*5 +: 5] = a;
        data[k*DW +: DW] = d;
    endtask

    task automatic idle(input int n);
        valid = '0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        valid = '0;
        addr  = '0;
        data  = '0;
        for (int r = 0; r < 32; r++) rf_dut[r] = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs();
        rst_n = 1'b1;
        idle(2);

        // Single result: visible on we_o exactly two edges after the handshake.
        drv(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cyc();
        valid = '0;
        chk("single_pend_t1", 32'(pending_o[5]), 32'd1);
        chk("single_we_t1", 32'(we_o), 32'd0);
        cyc();
        chk("single_we_t2", 32'(we_o), 32'd1);
        chk("single_addr_t2", 32'(waddr_o[4:0]), 32'd5);
        chk("single_data_t2", wdata_o[31:0], 32'hDEADBEEF);
        cyc();
        chk("single_we_t3", 32'(we_o), 32'd0);
        chk("single_pend_t3", 32'(pending_o[5]), 32'd0);
        idle(2);

        // All sources busy with distinct addresses: two writes every cycle.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NW; k++) drv(k, 1'b1, 5'(k + 1), 32'(100 * i + k));
            cyc();
            if (i >= 1) chk("tput", 32'(we_o), 32'd3);
        end
        idle(6);

        // Same-address conflict between sources 1 and 2 with rr at 1.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drv(0, 1'b1, 5'd9, 32'h0000_0009);
        cyc();
        valid = '0;
        drv(1, 1'b1, 5'd7, 32'hC0DE0001);
        drv(2, 1'b1, 5'd7, 32'hC0DE0002);
        cyc();
        valid = '0;
        cyc();
        chk("conf_we_a", 32'(we_o), 32'd1);
        chk("conf_data_a", wdata_o[31:0], 32'hC0DE0001);
        cyc();
        chk("conf_we_b", 32'(we_o), 32'd1);
        chk("conf_data_b", wdata_o[31:0], 32'hC0DE0002);
        idle(2);
        chk("conf_rf7", rf_dut[7], 32'hC0DE0002);

        // Writes to x0 are accepted and dropped.
        drv(3, 1'b1, 5'd0, 32'h0000_1234);
        cyc();
        valid = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("x0_we", 32'(we_o), 32'd0);
            chk("x0_pend", 32'(pending_o[0]), 32'd0);
        end

        // Fill every FIFO, then flush.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NW; k++) drv(k, 1'b1, 5'(10 + k), 32'(200 + i * 4 + k));
            cyc();
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(wb_ready_o), 32'd0);
        cyc();
        flush = 1'b0;
        chk("flush_we", 32'(we_o), 32'd0);
        chk("flush_pend", pending_o, 32'd0);
        valid = '0;
        #1;
        chk("post_flush_ready", 32'(wb_ready_o), 32'hF);
        idle(3);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NW; k++)
                drv(k, 1'(($urandom() % 3) != 0),
                    ($urandom() % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5)),
                    $urandom());
            flush = ($urandom_range(0, 24) == 0);
            cyc();
        end

        // Asynchronous reset between edges while traffic is flowing.
        for (int k = 0; k < NW; k++) drv(k, 1'b1, 5'(20 + k), 32'(300 + k));
        flush = 1'b0;
        cyc();
        cyc();
        @(posedge clk);
        model_edge();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_pend", pending_o, 32'd0);
        check_outs();
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drv(2, 1'b1, 5'd20, 32'hABCD0001);
        cyc();
        valid = '0;
        chk("rst_lat_t1", 32'(we_o), 32'd0);
        cyc();
        chk("rst_lat_t2", 32'(we_o), 32'd1);
        chk("rst_lat_addr", 32'(waddr_o[4:0]), 32'd20);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
